grant_bus_ctrl: RTL
===================

Name: grant_bus_ctrl

Overview:
- Downstream consumer of the 4-requester fixed-priority arbiter.
- Takes the registered one-hot grant and latches the winning master as bus owner.
- Runs a fixed-length burst on the shared data bus with a valid/ready handshake, then releases ownership with a per-master done pulse.
- Masks the request vector fed back to the arbiter while a burst is in flight, so ownership cannot change mid-burst.

Parameters:
- DATA_W, 8: width of each master's data word and of the shared bus.
- BURST_LEN, 4: beats per ownership tenure; legal range 1..16.
- TIMEOUT_CYC, 16: consecutive stall cycles before abort; used only when GRANT_BUS_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_in  input  4  raw master requests, bit 0 highest priority
- req_out  output  4  requests to arbiter: req_in when idle, 4'b0000 otherwise
- gnt  input  4  registered one-hot grant from the arbiter
- data_in  input  4*DATA_W  packed master data; master i occupies bits [i*DATA_W +: DATA_W]
- bus_valid  output  1  shared bus beat valid
- bus_data  output  DATA_W  shared bus data
- bus_owner  output  2  index of the current owner
- bus_ready  input  1  sink accepts the beat when bus_valid && bus_ready
- done  output  4  one-cycle pulse on the owner's bit when its burst completes
- busy  output  1  high whenever state != IDLE
- err  output  1  one-cycle pulse when gnt is not one-hot and not zero

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: state IDLE, owner 0, beat_cnt 0, bus_valid 0, done 0, err 0, busy 0, req_out 0. Reset has priority over all events, including mid-burst; the burst is dropped with no done pulse.
- States: IDLE, XFER, DONE.
- IDLE:
  - gnt one-hot: latch owner = index of the set bit, clear beat_cnt, go to XFER.
  - gnt == 0: stay in IDLE.
  - gnt multi-hot: pulse err for one cycle, stay in IDLE, take no ownership.
- XFER:
  - bus_valid = 1.
  - bus_data = combinational select of data_in slice [owner].
  - bus_owner = owner.
  - Beat accepted when bus_valid && bus_ready; beat_cnt increments. If bus_ready is low, hold: no count change.
  - On acceptance of beat BURST_LEN-1, go to DONE.
  - gnt is ignored in XFER.
- DONE: done[owner] = 1 for exactly one cycle, bus_valid = 0, then go to IDLE.
- Output registering: req_out = busy ? 4'b0000 : req_in, registered from state.
- Latency:
  - gnt valid in IDLE at cycle T gives first bus_valid at T+1.
  - With bus_ready held high, done pulses at T+1+BURST_LEN and IDLE resumes at T+2+BURST_LEN.
- Re-grant gap: because req_out is masked during XFER and DONE, gnt is 0 on the first IDLE cycle. A new grant arrives no earlier than 2 cycles after DONE, so there is no stale re-grant.
- Widths:
  - beat_cnt is 4 bits and compares against BURST_LEN-1 (no wrap past that value).
  - bus_owner is 2 bits.
- Outputs when not in XFER: bus_data = 0 and bus_owner holds the last owner.

Optional Feature:
- Macro: GRANT_BUS_TIMEOUT_EN.
- Defined:
  - A stall counter counts consecutive XFER cycles with bus_valid && !bus_ready.
  - When it reaches TIMEOUT_CYC, go to DONE, pulse done[owner] and pulse err in the same cycle. The burst is aborted.
  - Any accepted beat clears the stall counter.
- Undefined: no stall counter exists, and a stall holds XFER indefinitely.

Test Plan:
- Reset, then req_in=4'b0110: req_out=4'b0110. gnt=4'b0010 gives owner=1, 4 beats with data_in[15:8] on bus_data, done=4'b0010 one cycle, busy low afterwards.
- During XFER, req_in=4'b1111: req_out=4'b0000 throughout XFER and DONE. Changing gnt to 4'b0001 mid-burst does not change bus_owner.
- bus_ready toggling 1,0,0,1,1,0,1: exactly 4 beats accepted, done pulses one cycle after the 4th acceptance, bus_data stable across stalls.
- gnt=4'b0101 in IDLE: err pulses 1 cycle, busy stays 0, no bus_valid.
- rst asserted at beat 2 of a burst: next cycle bus_valid=0, busy=0, done=0. No done pulse follows.
- With GRANT_BUS_TIMEOUT_EN and TIMEOUT_CYC=16: bus_ready held low 16 cycles in XFER gives done[owner] and err pulsed together, then IDLE. With the macro undefined, the same stimulus keeps busy=1 indefinitely.

Source files
------------

// File: rtl/grant_bus_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | grant_bus_ctrl: latches the arbiter grant as bus owner, runs a fixed     |
// | burst, then releases with a done pulse. Option: GRANT_BUS_TIMEOUT_EN.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module grant_bus_ctrl #(
  parameter int DATA_W      = 8,
  parameter int BURST_LEN   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req_in,
  output logic [3:0]          req_out,
  input  logic [3:0]          gnt,
  input  logic [4*DATA_W-1:0] data_in,
  output logic                bus_valid,
  output logic [DATA_W-1:0]   bus_data,
  output logic [1:0]          bus_owner,
  input  logic                bus_ready,
  output logic [3:0]          done,
  output logic                busy,
  output logic                err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

  if (BURST_LEN < 1 || BURST_LEN > 16 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("grant_bus_ctrl: illegal BURST_LEN or TIMEOUT_CYC");
  end

  state_t     state;
  logic [1:0] owner;
  logic [3:0] beat_cnt;
  logic       gnt_multi;
  logic       gnt_onehot;
  logic [1:0] gnt_idx;

  // x & (x-1) clears the lowest set bit: nonzero means more than one bit set
  assign gnt_multi  = (gnt & (gnt - 4'd1)) != 4'd0;
  assign gnt_onehot = (gnt != 4'd0) && !gnt_multi;

  always_comb begin
    gnt_idx = 2'd0;
    case (gnt)
      4'b0010: gnt_idx = 2'd1;
      4'b0100: gnt_idx = 2'd2;
      4'b1000: gnt_idx = 2'd3;
      default: gnt_idx = 2'd0;
    endcase
  end

`ifdef GRANT_BUS_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);
  logic [STALL_W-1:0] stall_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 2'd0;
      beat_cnt  <= 4'd0;
      bus_valid <= 1'b0;
      done      <= 4'd0;
      err       <= 1'b0;
      busy      <= 1'b0;
      req_out   <= 4'd0;
`ifdef GRANT_BUS_TIMEOUT_EN
      stall_cnt <= '0;
`endif
    end else begin
      done <= 4'd0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_onehot) begin
            owner     <= gnt_idx;
            beat_cnt  <= 4'd0;
            state     <= XFER;
            bus_valid <= 1'b1;
            busy      <= 1'b1;
            req_out   <= 4'd0;
`ifdef GRANT_BUS_TIMEOUT_EN
            stall_cnt <= '0;
`endif
          end else begin
            err     <= gnt_multi;
            req_out <= req_in;
          end
        end
        XFER: begin
          // gnt is deliberately ignored here; ownership is fixed for the tenure
          req_out <= 4'd0;
          if (bus_ready) begin
`ifdef GRANT_BUS_TIMEOUT_EN
            stall_cnt <= '0;
`endif
            if (beat_cnt == LAST_BEAT) begin
              state     <= DONE;
              bus_valid <= 1'b0;
              done      <= 4'b0001 << owner;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
`ifdef GRANT_BUS_TIMEOUT_EN
          else if (stall_cnt == STALL_LAST) begin
            state     <= DONE;
            bus_valid <= 1'b0;
            done      <= 4'b0001 << owner;
            err       <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          req_out <= req_in;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          bus_valid <= 1'b0;
          req_out   <= 4'd0;
        end
      endcase
    end
  end

  assign bus_owner = owner;
  assign bus_data  = bus_valid ? data_in[owner*DATA_W +: DATA_W] : '0;

endmodule
`default_nettype wire
